// File: rtl/operand_fetch_if.sv
// Bus bundle between the upstream decode/control logic and the operand fetch stage.
// The master drives instruction, control, writeback and hazard signals; the slave returns the ID/EX register.
interface operand_fetch_if;
  logic [31:0] instruction;
  logic        valid_in;
  logic        aluSrc;
  logic        regDst;
  logic [1:0]  aluOp;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        stall;
  logic        flush;

  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] saidaMusReg;
  logic [3:0]  aluControlOut;
  logic [4:0]  writeRegOut;
  logic        valid_out;
  logic        illegal;

  modport master (
    output instruction, valid_in, aluSrc, regDst, aluOp,
           regWrite, writeReg, writeData, stall, flush,
    input  readData1, readData2, saidaMusReg, aluControlOut,
           writeRegOut, valid_out, illegal
  );

  modport slave (
    input  instruction, valid_in, aluSrc, regDst, aluOp,
           regWrite, writeReg, writeData, stall, flush,
    output readData1, readData2, saidaMusReg, aluControlOut,
           writeRegOut, valid_out, illegal
  );
endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: 32x32 register file with write-first bypass, ALU control decode,
// second-operand select and the ID/EX pipeline register with stall/flush handling.
module operand_fetch (
  input  logic           clock,
  input  logic           reset,
  operand_fetch_if.slave bus
);

  logic [31:0] rf_q [32];

  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [31:0] opb_q, opb_d;
  logic [3:0]  alu_q, alu_d;
  logic [4:0]  wr_q, wr_d;
  logic        valid_q, valid_d;
  logic        ill_q, ill_d;

  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [31:0] rs_val, rt_val;
  logic        wr_en;
  logic [3:0]  alu_dec;
  logic        ill_dec;

  logic unused_opcode;
  assign unused_opcode = ^bus.instruction[31:26];

  assign rs      = bus.instruction[25:21];
  assign rt      = bus.instruction[20:16];
  assign rd      = bus.instruction[15:11];
  assign funct   = bus.instruction[5:0];
  assign imm_ext = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
  assign wr_en   = bus.regWrite && (bus.writeReg != 5'd0);

  // Write-first read: a same-cycle writeback to the addressed register wins over the array.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) rs_val = (wr_en && bus.writeReg == rs) ? bus.writeData : rf_q[rs];
    if (rt != 5'd0) rt_val = (wr_en && bus.writeReg == rt) ? bus.writeData : rf_q[rt];
  end

  always_comb begin
    alu_dec = 4'b1111;
    ill_dec = 1'b1;
    unique case (bus.aluOp)
      2'b00: begin alu_dec = 4'b0010; ill_dec = 1'b0; end
      2'b01: begin alu_dec = 4'b0110; ill_dec = 1'b0; end
      2'b10: begin
        ill_dec = 1'b0;
        case (funct)
          6'b100000: alu_dec = 4'b0010;
          6'b100010: alu_dec = 4'b0110;
          6'b100100: alu_dec = 4'b0000;
          6'b100101: alu_dec = 4'b0001;
          6'b101010: alu_dec = 4'b0111;
          default: begin alu_dec = 4'b1111; ill_dec = 1'b1; end
        endcase
      end
      default: begin alu_dec = 4'b1111; ill_dec = 1'b1; end
    endcase
  end

  // Priority below reset: flush, then stall, then capture; an invalid capture loads as a bubble.
  always_comb begin
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    opb_d   = opb_q;
    alu_d   = alu_q;
    wr_d    = wr_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      alu_d   = 4'b0000;
      ill_d   = 1'b0;
      wr_d    = 5'd0;
    end else if (!bus.stall) begin
      rd1_d = rs_val;
      rd2_d = rt_val;
      opb_d = bus.aluSrc ? imm_ext : rt_val;
      if (bus.valid_in) begin
        valid_d = 1'b1;
        alu_d   = alu_dec;
        ill_d   = ill_dec;
        wr_d    = bus.regDst ? rd : rt;
      end else begin
        valid_d = 1'b0;
        alu_d   = 4'b0000;
        ill_d   = 1'b0;
        wr_d    = 5'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      opb_q   <= '0;
      alu_q   <= '0;
      wr_q    <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      if (wr_en) rf_q[bus.writeReg] <= bus.writeData;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      opb_q   <= opb_d;
      alu_q   <= alu_d;
      wr_q    <= wr_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.readData1     = rd1_q;
  assign bus.readData2     = rd2_q;
  assign bus.saidaMusReg   = opb_q;
  assign bus.aluControlOut = alu_q;
  assign bus.writeRegOut   = wr_q;
  assign bus.valid_out     = valid_q;
  assign bus.illegal       = ill_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: stimulus pushes expected ID/EX contents into a queue,
// a negedge monitor pops one entry per valid output cycle and compares.
module tb_operand_fetch;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  operand_fetch_if bus ();
  operand_fetch dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] opb;
    logic [3:0]  alu;
    logic [4:0]  wr;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_valid: got valid_out=1 expected no pending entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("readData1",     bus.readData1,            e.rd1);
        chk("readData2",     bus.readData2,            e.rd2);
        chk("saidaMusReg",   bus.saidaMusReg,          e.opb);
        chk("aluControlOut", {28'd0, bus.aluControlOut}, {28'd0, e.alu});
        chk("writeRegOut",   {27'd0, bus.writeRegOut},   {27'd0, e.wr});
        chk("illegal",       {31'd0, bus.illegal},       {31'd0, e.ill});
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] rs, rt, input logic [15:0] imm);
    return {6'd8, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [1:0] op, input logic src, input logic dst);
    bus.instruction = ins;
    bus.aluOp       = op;
    bus.aluSrc      = src;
    bus.regDst      = dst;
    bus.valid_in    = 1'b1;
  endtask

  task automatic push(input logic [31:0] r1, r2, ob, input logic [3:0] a, input logic [4:0] w, input logic il);
    exp_t e;
    e.rd1 = r1; e.rd2 = r2; e.opb = ob; e.alu = a; e.wr = w; e.ill = il;
    sb.push_back(e);
  endtask

  task automatic write_rf(input logic [4:0] r, input logic [31:0] d);
    bus.valid_in  = 1'b0;
    bus.regWrite  = 1'b1;
    bus.writeReg  = r;
    bus.writeData = d;
    cyc();
    bus.regWrite  = 1'b0;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_out},       32'd0);
    chk({tag, "_alu"},   {28'd0, bus.aluControlOut},   32'd0);
    chk({tag, "_ill"},   {31'd0, bus.illegal},         32'd0);
    chk({tag, "_wr"},    {27'd0, bus.writeRegOut},     32'd0);
  endtask

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_BAD = 6'b000011;

  initial begin
    reset = 1'b1;
    bus.instruction = '0; bus.valid_in = 1'b0; bus.aluSrc = 1'b0; bus.regDst = 1'b0;
    bus.aluOp = 2'b00; bus.regWrite = 1'b0; bus.writeReg = '0; bus.writeData = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    repeat (2) cyc();
    chk_bubble("reset");
    chk("reset_rd1", bus.readData1, 32'd0);
    chk("reset_rd2", bus.readData2, 32'd0);
    chk("reset_opb", bus.saidaMusReg, 32'd0);
    reset = 1'b0;

    for (int i = 1; i < 32; i++) begin
      send(rtype(5'(i), 5'(i), 5'd0, F_ADD), 2'b00, 1'b0, 1'b0);
      push(32'd0, 32'd0, 32'd0, 4'b0010, 5'(i), 1'b0);
      cyc();
    end

    write_rf(5'd1, 32'd5);
    write_rf(5'd2, 32'd7);

    send(rtype(5'd1, 5'd2, 5'd3, F_ADD), 2'b10, 1'b0, 1'b1);
    push(32'd5, 32'd7, 32'd7, 4'b0010, 5'd3, 1'b0);
    cyc();

    send(itype(5'd4, 5'd5, 16'hFFFC), 2'b00, 1'b1, 1'b0);
    bus.regWrite = 1'b1; bus.writeReg = 5'd4; bus.writeData = 32'h12345678;
    push(32'h12345678, 32'd0, 32'hFFFFFFFC, 4'b0010, 5'd5, 1'b0);
    cyc();
    bus.regWrite = 1'b0;
    send(itype(5'd4, 5'd0, 16'h0001), 2'b00, 1'b1, 1'b0);
    push(32'h12345678, 32'd0, 32'd1, 4'b0010, 5'd0, 1'b0);
    cyc();

    send(itype(5'd1, 5'd2, 16'h8000), 2'b00, 1'b1, 1'b0);
    push(32'd5, 32'd7, 32'hFFFF8000, 4'b0010, 5'd2, 1'b0);
    cyc();
    send(itype(5'd1, 5'd2, 16'h7FFF), 2'b00, 1'b1, 1'b0);
    push(32'd5, 32'd7, 32'h00007FFF, 4'b0010, 5'd2, 1'b0);
    cyc();

    send(rtype(5'd0, 5'd0, 5'd3, F_ADD), 2'b10, 1'b0, 1'b1);
    bus.regWrite = 1'b1; bus.writeReg = 5'd0; bus.writeData = 32'h0000DEAD;
    push(32'd0, 32'd0, 32'd0, 4'b0010, 5'd3, 1'b0);
    cyc();
    bus.regWrite = 1'b0;
    push(32'd0, 32'd0, 32'd0, 4'b0010, 5'd3, 1'b0);
    cyc();

    send(rtype(5'd2, 5'd1, 5'd3, F_SUB), 2'b10, 1'b0, 1'b1);
    push(32'd7, 32'd5, 32'd5, 4'b0110, 5'd3, 1'b0);
    cyc();
    send(rtype(5'd2, 5'd1, 5'd3, F_AND), 2'b10, 1'b0, 1'b1);
    push(32'd7, 32'd5, 32'd5, 4'b0000, 5'd3, 1'b0);
    cyc();
    send(rtype(5'd2, 5'd1, 5'd3, F_OR), 2'b10, 1'b0, 1'b1);
    push(32'd7, 32'd5, 32'd5, 4'b0001, 5'd3, 1'b0);
    cyc();
    send(rtype(5'd2, 5'd1, 5'd3, F_SLT), 2'b10, 1'b0, 1'b1);
    push(32'd7, 32'd5, 32'd5, 4'b0111, 5'd3, 1'b0);
    cyc();
    send(rtype(5'd1, 5'd2, 5'd3, F_BAD), 2'b10, 1'b0, 1'b1);
    push(32'd5, 32'd7, 32'd7, 4'b1111, 5'd3, 1'b1);
    cyc();
    send(rtype(5'd1, 5'd2, 5'd3, F_ADD), 2'b01, 1'b0, 1'b0);
    push(32'd5, 32'd7, 32'd7, 4'b0110, 5'd2, 1'b0);
    cyc();
    send(rtype(5'd1, 5'd2, 5'd3, F_ADD), 2'b11, 1'b0, 1'b0);
    push(32'd5, 32'd7, 32'd7, 4'b1111, 5'd2, 1'b1);
    cyc();

    send(rtype(5'd1, 5'd2, 5'd3, F_BAD), 2'b10, 1'b0, 1'b1);
    bus.valid_in = 1'b0;
    cyc();
    chk_bubble("bubble");

    send(rtype(5'd2, 5'd2, 5'd6, F_ADD), 2'b10, 1'b0, 1'b1);
    push(32'd7, 32'd7, 32'd7, 4'b0010, 5'd6, 1'b0);
    cyc();
    send(rtype(5'd1, 5'd2, 5'd3, F_ADD), 2'b10, 1'b0, 1'b1);
    bus.stall = 1'b1;
    push(32'd7, 32'd7, 32'd7, 4'b0010, 5'd6, 1'b0);
    cyc();
    bus.regWrite = 1'b1; bus.writeReg = 5'd1; bus.writeData = 32'd9;
    push(32'd7, 32'd7, 32'd7, 4'b0010, 5'd6, 1'b0);
    cyc();
    bus.regWrite = 1'b0;
    push(32'd7, 32'd7, 32'd7, 4'b0010, 5'd6, 1'b0);
    cyc();
    bus.stall = 1'b0;
    push(32'd9, 32'd7, 32'd7, 4'b0010, 5'd3, 1'b0);
    cyc();

    send(rtype(5'd1, 5'd2, 5'd3, F_BAD), 2'b10, 1'b0, 1'b1);
    push(32'd9, 32'd7, 32'd7, 4'b1111, 5'd3, 1'b1);
    cyc();
    send(rtype(5'd1, 5'd2, 5'd3, F_ADD), 2'b10, 1'b0, 1'b1);
    bus.stall = 1'b1; bus.flush = 1'b1;
    cyc();
    chk_bubble("stall_flush");
    bus.stall = 1'b0; bus.flush = 1'b0;

    send(rtype(5'd1, 5'd2, 5'd3, F_ADD), 2'b10, 1'b0, 1'b1);
    push(32'd9, 32'd7, 32'd7, 4'b0010, 5'd3, 1'b0);
    cyc();
    bus.stall = 1'b1; reset = 1'b1;
    cyc();
    chk_bubble("reset_stall");
    chk("reset_stall_rd1", bus.readData1, 32'd0);
    chk("reset_stall_opb", bus.saidaMusReg, 32'd0);
    bus.stall = 1'b0; reset = 1'b0;
    send(rtype(5'd1, 5'd2, 5'd3, F_ADD), 2'b10, 1'b0, 1'b1);
    push(32'd0, 32'd0, 32'd0, 4'b0010, 5'd3, 1'b0);
    cyc();

    bus.valid_in = 1'b0;
    repeat (3) cyc();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
